// File: rtl/led_pattern_sequencer_if.sv
// ROM fetch and LED write port bundle between the pattern sequencer, its pattern ROM and
// led_interface.
interface led_pattern_sequencer_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
);
  logic [AddrWidth-1:0] rom_addr;
  logic                 rom_read_req;
  logic [DataWidth-1:0] rom_read_data;
  logic                 rom_read_data_valid;
  logic                 led_write_req;
  logic [DataWidth-1:0] led_write_data;
  logic [3:0]           led_byte_enable;

  modport master (
    output rom_addr,
    output rom_read_req,
    input  rom_read_data,
    input  rom_read_data_valid,
    output led_write_req,
    output led_write_data,
    output led_byte_enable
  );

  modport slave (
    input  rom_addr,
    input  rom_read_req,
    output rom_read_data,
    output rom_read_data_valid,
    input  led_write_req,
    input  led_write_data,
    input  led_byte_enable
  );
endinterface

// File: rtl/led_pattern_sequencer.sv
// Walks a pattern ROM one entry at a time: fetch, wait for data, single-cycle LED write,
// then hold for a fixed dwell before advancing (wrapping or stopping at the last entry).
module led_pattern_sequencer #(
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned Depth      = 5,
  parameter int unsigned AddrStride = 1,
  parameter int unsigned Dwell      = 4,
  parameter logic [3:0]  ByteEnable = 4'h1,
  parameter bit          Loop       = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  led_pattern_sequencer_if.master   bus,
  output logic                      busy,
  output logic                      wrap_pulse,
  output logic                      done
);

  localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = (Dwell > 1) ? $clog2(Dwell) : 1;
  localparam logic [IdxW-1:0] LastIdx   = IdxW'(Depth - 1);
  localparam logic [CntW-1:0] DwellLoad = CntW'(Dwell - 1);

  typedef enum logic [2:0] {
    StIdle, StFetch, StWait, StWrite, StDwell, StDone
  } state_e;

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        index_q, index_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [DataWidth-1:0]   data_q, data_d;
  logic                   dwell_last;
  logic                   at_last;

  assign dwell_last = (state_q == StDwell) && (cnt_q == '0);
  assign at_last    = (index_q == LastIdx);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      index_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle:  if (enable) state_d = StFetch;
      StFetch: state_d = StWait;
      StWait: begin
        if (bus.rom_read_data_valid) begin
          data_d  = bus.rom_read_data;
          state_d = StWrite;
        end
      end
      StWrite: begin
        cnt_d   = DwellLoad;
        state_d = StDwell;
      end
      StDwell: begin
        if (dwell_last) begin
          index_d = at_last ? '0 : index_q + 1'b1;
          // A one-shot run parks in DONE regardless of enable.
          if (!Loop && at_last) state_d = StDone;
          else                  state_d = enable ? StFetch : StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone:  if (!enable) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.rom_read_req    = (state_q == StFetch);
    bus.rom_addr        = AddrWidth'(index_q) * AddrWidth'(AddrStride);
    bus.led_write_req   = (state_q == StWrite);
    bus.led_write_data  = data_q;
    bus.led_byte_enable = ByteEnable;
    busy                = (state_q != StIdle) && (state_q != StDone);
    done                = (state_q == StDone);
    wrap_pulse          = Loop && dwell_last && at_last;
  end

endmodule
